// File: rtl/matmul_pkg.sv
// Shared types for the matmul job sequencer: descriptor layout, FSM states and validation helper.
package matmul_pkg;

    localparam int ADDR_W  = 28;
    localparam int BURST_W = 7;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr0;
        logic [ADDR_W-1:0]  addr1;
        logic [ADDR_W-1:0]  res_addr;
        logic [ADDR_W-1:0]  len;
        logic [BURST_W-1:0] burst;
    } job_desc_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        START,
        RUN
    } seq_state_e;

    // A descriptor is legal when the burst is 1..max_b and the length is a non-zero multiple of it.
    function automatic logic desc_ok(input job_desc_t d, input logic [BURST_W-1:0] max_b);
        logic [ADDR_W-1:0] burst_ext;
        burst_ext = {{(ADDR_W-BURST_W){1'b0}}, d.burst};
        return (d.burst != '0) && (d.burst <= max_b) && (d.len != '0) &&
               ((d.len % burst_ext) == '0);
    endfunction

endpackage

// File: rtl/job_desc_fifo.sv
// Synchronous descriptor FIFO with flush; head is presented combinationally on rdata.
module job_desc_fifo
    import matmul_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  job_desc_t                wdata,
    input  logic                     pop,
    output job_desc_t                rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    job_desc_t       mem [DEPTH];
    logic [PW-1:0]   wptr;
    logic [PW-1:0]   rptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/matmul_job_sequencer.sv
// Queues matrix-op descriptors and runs the DRAM matrix-add agent one job at a time.
// MJS_PERF_CNT_EN adds perf_last_cycles (RUN-cycle count of the last completed job).
module matmul_job_sequencer
    import matmul_pkg::*;
#(
    parameter int JOB_DEPTH      = 4,
    parameter int MAX_BURST      = 32,
    parameter int TIMEOUT_CYCLES = 2**24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [ADDR_W-1:0] job_addr0,
    input  logic [ADDR_W-1:0] job_addr1,
    input  logic [ADDR_W-1:0] job_res_addr,
    input  logic [ADDR_W-1:0] job_len,
    input  logic [6:0]        job_burst,
    output logic              job_reject,
    input  logic              abort,
    output logic [ADDR_W-1:0] mat_address0,
    output logic [ADDR_W-1:0] mat_address1,
    output logic [ADDR_W-1:0] mat_res_address,
    output logic [ADDR_W-1:0] mat_mem_len,
    output logic [ADDR_W-1:0] burst_setting,
    output logic              agent_start,
    output logic              agent_start_ff,
    input  logic              agent_done,
    output logic              busy,
    output logic              job_done,
    output logic [15:0]       jobs_completed,
    output logic              timeout_err
`ifdef MJS_PERF_CNT_EN
    ,
    output logic [31:0]       perf_last_cycles
`endif
);

    localparam logic [BURST_W-1:0] MAX_B   = BURST_W'(MAX_BURST);
    localparam logic [31:0]        TO_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;

    seq_state_e                    state_q, state_d;
    job_desc_t                     in_desc, head;
    logic                          fifo_full, fifo_empty;
    logic [$clog2(JOB_DEPTH):0]    fifo_count;
    logic                          accept, in_ok, push, pop, flush;
    logic                          done_ev, tmo_ev;
    logic [31:0]                   cyc;

    assign in_desc = '{addr0: job_addr0, addr1: job_addr1, res_addr: job_res_addr,
                       len: job_len, burst: job_burst};
    assign in_ok   = desc_ok(in_desc, MAX_B);
    // Abort suppresses any same-cycle accept, so the flushed queue stays empty.
    assign accept  = job_valid && job_ready && !abort;
    assign push    = accept && in_ok;

    assign job_ready      = !fifo_full;
    assign busy           = (state_q != IDLE) || (fifo_count != '0);
    assign agent_start    = (state_q == START);
    assign agent_start_ff = (state_q == START) || (state_q == RUN);

    job_desc_fifo #(.DEPTH(JOB_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .push  (push),
        .wdata (in_desc),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        done_ev = 1'b0;
        tmo_ev  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = LOAD;
                    pop     = 1'b1;
                end
            end
            LOAD:  state_d = START;
            START: state_d = RUN;
            RUN: begin
                if (agent_done) begin
                    state_d = IDLE;
                    done_ev = 1'b1;
                end else if ((TIMEOUT_CYCLES != 0) && (cyc == TO_LAST)) begin
                    state_d = IDLE;
                    tmo_ev  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
            pop     = 1'b0;
            done_ev = 1'b0;
            tmo_ev  = 1'b0;
        end
        flush = abort || tmo_ev;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            mat_address0    <= '0;
            mat_address1    <= '0;
            mat_res_address <= '0;
            mat_mem_len     <= '0;
            burst_setting   <= '0;
            cyc             <= '0;
            job_reject      <= 1'b0;
            job_done        <= 1'b0;
            jobs_completed  <= '0;
            timeout_err     <= 1'b0;
`ifdef MJS_PERF_CNT_EN
            perf_last_cycles <= '0;
`endif
        end else begin
            state_q    <= state_d;
            job_reject <= accept && !in_ok;
            job_done   <= done_ev;
            if (done_ev) jobs_completed <= jobs_completed + 16'd1;
            if (tmo_ev)  timeout_err    <= 1'b1;
            // The popped head is latched here and held until the next job is popped.
            if (pop) begin
                mat_address0    <= head.addr0;
                mat_address1    <= head.addr1;
                mat_res_address <= head.res_addr;
                mat_mem_len     <= head.len;
                burst_setting   <= {{(ADDR_W-BURST_W){1'b0}}, head.burst};
            end
            if (state_q == START) begin
                cyc <= '0;
            end else if ((state_q == RUN) && (cyc != '1)) begin
                cyc <= cyc + 32'd1;
            end
`ifdef MJS_PERF_CNT_EN
            if (done_ev) perf_last_cycles <= (cyc == '1) ? cyc : cyc + 32'd1;
`endif
        end
    end

endmodule

// File: tb/tb_matmul_job_sequencer.sv
// Scoreboard bench for matmul_job_sequencer; build with MJS_PERF_CNT_EN to cover perf_last_cycles.
module tb_matmul_job_sequencer;
    import matmul_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        job_valid = 1'b0;
    logic        job_ready;
    logic [27:0] job_addr0 = '0, job_addr1 = '0, job_res_addr = '0, job_len = '0;
    logic [6:0]  job_burst = '0;
    logic        job_reject;
    logic        abort = 1'b0;
    logic [27:0] mat_address0, mat_address1, mat_res_address, mat_mem_len, burst_setting;
    logic        agent_start, agent_start_ff;
    logic        agent_done;
    logic        busy, job_done, timeout_err;
    logic [15:0] jobs_completed;
`ifdef MJS_PERF_CNT_EN
    logic [31:0] perf_last_cycles;
    localparam int CNT_FINAL = 8;
`else
    localparam int CNT_FINAL = 7;
`endif

    always #5 clk = ~clk;

    matmul_job_sequencer #(.JOB_DEPTH(4), .MAX_BURST(32), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .reset(reset), .job_valid(job_valid), .job_ready(job_ready),
        .job_addr0(job_addr0), .job_addr1(job_addr1), .job_res_addr(job_res_addr),
        .job_len(job_len), .job_burst(job_burst), .job_reject(job_reject), .abort(abort),
        .mat_address0(mat_address0), .mat_address1(mat_address1),
        .mat_res_address(mat_res_address), .mat_mem_len(mat_mem_len),
        .burst_setting(burst_setting), .agent_start(agent_start),
        .agent_start_ff(agent_start_ff), .agent_done(agent_done), .busy(busy),
        .job_done(job_done), .jobs_completed(jobs_completed), .timeout_err(timeout_err)
`ifdef MJS_PERF_CNT_EN
        , .perf_last_cycles(perf_last_cycles)
`endif
    );

    int        checks = 0;
    int        errors = 0;
    job_desc_t exp_desc_q[$];
    int        exp_done_q[$];
    int        exp_rej = 0;
    int        run_len = 5;
    bit        agent_hang = 1'b0;
    job_desc_t cur;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Agent model: start clears done; done rises so that RUN lasts run_len cycles.
    initial begin
        agent_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && agent_start) begin
                agent_done = 1'b0;
                if (!agent_hang) begin
                    repeat (run_len) @(negedge clk);
                    agent_done = 1'b1;
                end
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a start, done or reject.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (agent_start) begin
                    chk("start_has_job", 128'(exp_desc_q.size() != 0), 128'(1));
                    if (exp_desc_q.size() != 0) begin
                        cur = exp_desc_q.pop_front();
                        chk("start_addrs", {mat_address0, mat_address1, mat_res_address, mat_mem_len},
                            {cur.addr0, cur.addr1, cur.res_addr, cur.len});
                        chk("start_burst", 128'(burst_setting), 128'(cur.burst));
                        chk("start_ff", 128'(agent_start_ff), 128'(1));
                    end
                end
                if (job_done) begin
                    chk("done_expected", 128'(exp_done_q.size() != 0), 128'(1));
                    if (exp_done_q.size() != 0)
                        chk("jobs_completed", 128'(jobs_completed), 128'(exp_done_q.pop_front()));
                    chk("done_addrs_stable", {mat_address0, mat_address1, mat_res_address, mat_mem_len},
                        {cur.addr0, cur.addr1, cur.res_addr, cur.len});
                end
                if (job_reject) begin
                    chk("reject_expected", 128'(exp_rej != 0), 128'(1));
                    if (exp_rej > 0) exp_rej--;
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge with job_valid still high.
    task automatic offer(input logic [27:0] a0, input logic [27:0] a1, input logic [27:0] r,
                         input logic [27:0] l, input logic [6:0] b, input bit ok, input int done_cnt);
        job_desc_t d;
        int t;
        d = '{a0, a1, r, l, b};
        job_valid = 1'b1;
        job_addr0 = a0; job_addr1 = a1; job_res_addr = r; job_len = l; job_burst = b;
        t = 0;
        while (!job_ready && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (t >= 400) chk("job_ready_wait", 128'(job_ready), 128'(1));
        if (ok) begin
            exp_desc_q.push_back(d);
            if (done_cnt >= 0) exp_done_q.push_back(done_cnt);
        end else begin
            exp_rej++;
        end
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) chk("busy_wait", 128'(busy), 128'(0));
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_start();
        int t = 0;
        while (!agent_start && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("start_wait", 128'(agent_start), 128'(1));
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_ready", 128'(job_ready), 128'(1));
        chk("rst_addrs", {mat_address0, mat_address1, mat_res_address, mat_mem_len}, 128'(0));
        chk("rst_misc", 128'({jobs_completed, timeout_err, job_done, job_reject, agent_start,
                              agent_start_ff, burst_setting}), 128'(0));

        // Single job
        run_len = 5;
        offer(28'h0, 28'h100, 28'h200, 28'h40, 7'd4, 1'b1, 1);
        job_valid = 1'b0;
        wait_idle();

        // Illegal descriptors
        offer(28'h10, 28'h20, 28'h30, 28'h40, 7'd0,  1'b0, -1);
        offer(28'h10, 28'h20, 28'h30, 28'h40, 7'd33, 1'b0, -1);
        offer(28'h10, 28'h20, 28'h30, 28'h41, 7'd4,  1'b0, -1);
        job_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("rej_not_busy", 128'(busy), 128'(0));
        chk("rej_count", 128'(jobs_completed), 128'(1));

        // Fill queue behind a running job; sixth offer stalls until the next pop
        run_len = 30;
        offer(28'h1000, 28'h2000, 28'h3000, 28'h80,  7'd32, 1'b1, 2);
        offer(28'h1100, 28'h2100, 28'h3100, 28'h7,   7'd1,  1'b1, 3);
        offer(28'h1200, 28'h2200, 28'h3200, 28'h30,  7'd8,  1'b1, 4);
        offer(28'h1300, 28'h2300, 28'h3300, 28'h60,  7'd3,  1'b1, 5);
        offer(28'h1400, 28'h2400, 28'h3400, 28'h100, 7'd16, 1'b1, 6);
        chk("full_ready_low", 128'(job_ready), 128'(0));
        offer(28'h1500, 28'h2500, 28'h3500, 28'h20,  7'd2,  1'b1, 7);
        chk("stall_until_pop", 128'(jobs_completed), 128'(2));
        job_valid = 1'b0;
        wait_idle();
        chk("fill_count", 128'(jobs_completed), 128'(7));

`ifdef MJS_PERF_CNT_EN
        run_len = 50;
        offer(28'h4000, 28'h5000, 28'h6000, 28'h40, 7'd4, 1'b1, 8);
        job_valid = 1'b0;
        wait_idle();
        chk("perf_last_cycles", 128'(perf_last_cycles), 128'(50));
`endif

        // Abort in RUN with two queued
        run_len = 60;
        offer(28'h7000, 28'h7100, 28'h7200, 28'h40, 7'd4, 1'b1, -1);
        offer(28'h7300, 28'h7400, 28'h7500, 28'h40, 7'd4, 1'b1, -1);
        offer(28'h7600, 28'h7700, 28'h7800, 28'h40, 7'd4, 1'b1, -1);
        job_valid = 1'b0;
        wait_start();
        repeat (5) @(negedge clk);
        chk("abort_pre_ff", 128'(agent_start_ff), 128'(1));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_ff", 128'(agent_start_ff), 128'(0));
        chk("abort_busy", 128'(busy), 128'(0));
        chk("abort_ready", 128'(job_ready), 128'(1));
        exp_desc_q.delete();
        repeat (80) @(negedge clk);
        chk("abort_no_done", 128'(jobs_completed), 128'(CNT_FINAL));

        // Watchdog
        agent_hang = 1'b1;
        offer(28'h8000, 28'h8100, 28'h8200, 28'h40, 7'd4, 1'b1, -1);
        job_valid = 1'b0;
        wait_start();
        repeat (100) @(negedge clk);
        chk("tmo_run100_ff", 128'(agent_start_ff), 128'(1));
        chk("tmo_run100_err", 128'(timeout_err), 128'(0));
        @(negedge clk);
        chk("tmo_err", 128'(timeout_err), 128'(1));
        chk("tmo_ff", 128'(agent_start_ff), 128'(0));
        chk("tmo_busy", 128'(busy), 128'(0));
        repeat (10) @(negedge clk);
        chk("tmo_sticky", 128'(timeout_err), 128'(1));
        chk("tmo_no_done", 128'(jobs_completed), 128'(CNT_FINAL));

        // Reset while in START
        offer(28'h9000, 28'h9100, 28'h9200, 28'h40, 7'd4, 1'b1, -1);
        job_valid = 1'b0;
        wait_start();
        #1 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst2_addrs", {mat_address0, mat_address1, mat_res_address, mat_mem_len}, 128'(0));
        chk("rst2_misc", 128'({jobs_completed, timeout_err, job_done, job_reject, agent_start,
                               agent_start_ff, busy, burst_setting}), 128'(0));
`ifdef MJS_PERF_CNT_EN
        chk("rst2_perf", 128'(perf_last_cycles), 128'(0));
`endif
        repeat (5) @(negedge clk);

        chk("desc_q_drained", 128'(exp_desc_q.size()), 128'(0));
        chk("done_q_drained", 128'(exp_done_q.size()), 128'(0));
        chk("rejects_seen", 128'(exp_rej), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
